// File: rtl/universal_shift_reg.sv
// universal_shift_reg
//   Universal shift register with single-step operations and a counted burst
//   engine. Each step applies one mode operation: hold, parallel load, logical
//   shift left/right with serial inputs, rotate left/right, or arithmetic
//   shift right.
//
//   A burst is requested with start and count. The register then performs
//   count operations in the mode captured at the request, one per clock. It
//   flags completion with a one-cycle done pulse.
//
// Ports
//   clk    rising-edge clock
//   res    synchronous active-high reset (q=0, burst aborted)
//   pre    synchronous active-high preset (q=PRE_VAL, burst aborted)
//   en     single-step enable while idle
//   mode   operation select:
//             000 hold, 001 load, 010 shl, 011 shr,
//             100 rol, 101 ror, 110 asr, 111 hold
//   d      parallel load data
//   sin_l  serial input for left shift (enters bit 0)
//   sin_r  serial input for right shift (enters bit WIDTH-1)
//   start  burst request
//   count  burst length (0 completes immediately)
//   q      register value
//   sout   serial out: MSB for left-type modes, else LSB
//   busy   burst in progress
//   done   one-cycle burst-complete pulse
module universal_shift_reg #(
   parameter int                 WIDTH   = 8,
   parameter int                 CNT_W   = 4,
   parameter logic [WIDTH-1:0]   PRE_VAL = {WIDTH{1'b1}}
) (
   input  logic                clk,
   input  logic                res,
   input  logic                pre,
   input  logic                en,
   input  logic [2:0]          mode,
   input  logic [WIDTH-1:0]    d,
   input  logic                sin_l,
   input  logic                sin_r,
   input  logic                start,
   input  logic [CNT_W-1:0]    count,
   output logic [WIDTH-1:0]    q,
   output logic                sout,
   output logic                busy,
   output logic                done
);

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_LOAD = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_SHR  = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             state_reg;
   logic [WIDTH-1:0]   q_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [2:0]         mode_reg;
   logic               done_reg;

   logic [2:0]         eff_mode;
   logic [WIDTH-1:0]   step_next;
   logic [WIDTH-1:0]   shl_v;
   logic [WIDTH-1:0]   shr_v;
   logic [WIDTH-1:0]   rol_v;
   logic [WIDTH-1:0]   ror_v;
   logic [WIDTH-1:0]   asr_v;
   logic               burst_mode_ok;

   // During a burst the captured mode drives both the datapath and sout.
   // Otherwise the live mode input drives them.
   assign eff_mode = (state_reg == S_RUN) ? mode_reg : mode;

   // Per-bit neighbour selection for every shift/rotate flavour. The end bits
   // take the serial input, the wrapped bit, or the replicated sign bit.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
         assign shl_v[gi] = sin_l;
         assign rol_v[gi] = q_reg[WIDTH-1];
      end else begin : g_lo
         assign shl_v[gi] = q_reg[gi-1];
         assign rol_v[gi] = q_reg[gi-1];
      end

      if (gi == WIDTH-1) begin : g_msb
         assign shr_v[gi] = sin_r;
         assign ror_v[gi] = q_reg[0];
         assign asr_v[gi] = q_reg[WIDTH-1];
      end else begin : g_hi
         assign shr_v[gi] = q_reg[gi+1];
         assign ror_v[gi] = q_reg[gi+1];
         assign asr_v[gi] = q_reg[gi+1];
      end
   end

   // Result of one operation in the effective mode.
   always_comb begin
      step_next = q_reg;
      case (eff_mode)
         MODE_LOAD: step_next = d;
         MODE_SHL:  step_next = shl_v;
         MODE_SHR:  step_next = shr_v;
         MODE_ROL:  step_next = rol_v;
         MODE_ROR:  step_next = ror_v;
         MODE_ASR:  step_next = asr_v;
         default:   step_next = q_reg;
      endcase
   end

   // Only the shift/rotate modes (010..110) can run as a burst. Hold and load
   // requests complete immediately without touching q.
   assign burst_mode_ok = (mode >= MODE_SHL) && (mode <= MODE_ASR);

   always_ff @(posedge clk) begin
      if (res) begin
         q_reg     <= '0;
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         mode_reg  <= MODE_HOLD;
         done_reg  <= 1'b0;
      end else if (pre) begin
         q_reg     <= PRE_VAL;
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         // done is a pulse: cleared every edge unless set again below.
         done_reg <= 1'b0;
         case (state_reg)
            S_RUN: begin
               // While running, en, d, mode and start are all ignored.
               q_reg <= step_next;
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg <= S_IDLE;
                  cnt_reg   <= '0;
                  done_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            default: begin
               if (start) begin
                  if (burst_mode_ok && (count != '0)) begin
                     // The acceptance edge only captures the request.
                     // The first operation happens on the following edge.
                     mode_reg  <= mode;
                     cnt_reg   <= count;
                     state_reg <= S_RUN;
                  end else begin
                     done_reg <= 1'b1;
                  end
               end else if (en) begin
                  q_reg <= step_next;
               end
            end
         endcase
      end
   end

   assign q    = q_reg;
   assign busy = (state_reg == S_RUN);
   assign done = done_reg;
   assign sout = ((eff_mode == MODE_SHL) || (eff_mode == MODE_ROL)) ? q_reg[WIDTH-1]
                                                                     : q_reg[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg
//   Directed-vector bench for universal_shift_reg (WIDTH=8, CNT_W=4,
//   PRE_VAL=FF). Every expected value below is hand-computed from the
//   operation definitions.
module tb_universal_shift_reg;

   logic       clk;
   logic       res;
   logic       pre;
   logic       en;
   logic [2:0] mode;
   logic [7:0] d;
   logic       sin_l;
   logic       sin_r;
   logic       start;
   logic [3:0] count;
   logic [7:0] q;
   logic       sout;
   logic       busy;
   logic       done;

   int n_checks;
   int n_errors;

   universal_shift_reg #(
      .WIDTH   (8),
      .CNT_W   (4),
      .PRE_VAL (8'hFF)
   ) dut (
      .clk   (clk),
      .res   (res),
      .pre   (pre),
      .en    (en),
      .mode  (mode),
      .d     (d),
      .sin_l (sin_l),
      .sin_r (sin_r),
      .start (start),
      .count (count),
      .q     (q),
      .sout  (sout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance one rising edge, then settle so outputs are sampled off the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single-step parallel load of a value into q.
   task automatic load(input logic [7:0] val);
      mode  = 3'b001;
      d     = val;
      en    = 1'b1;
      start = 1'b0;
      tick();
      en    = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      res = 1'b1; pre = 1'b1; en = 1'b1; mode = 3'b010; d = 8'h00;
      sin_l = 1'b0; sin_r = 1'b0; start = 1'b1; count = 4'd3;

      // Reset wins over preset, start and en.
      tick();
      check("rst_q",    32'(q),    32'h00);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);

      // Preset on the very first edge after reset is released.
      res = 1'b0; pre = 1'b1; start = 1'b0; en = 1'b0;
      tick();
      check("pre_q", 32'(q), 32'hFF);
      pre = 1'b0;

      // Single-step operations.
      load(8'hA5);
      check("load_q", 32'(q), 32'hA5);
      mode = 3'b100; en = 1'b1; tick();
      check("rol_q", 32'(q), 32'h4B);
      mode = 3'b110; tick();
      check("asr_q", 32'(q), 32'h25);
      mode = 3'b011; sin_r = 1'b1; tick();
      check("shr_q", 32'(q), 32'h92);
      check("sout_shr_lsb", 32'(sout), 32'h0);
      mode = 3'b010; #1;
      check("sout_shl_msb", 32'(sout), 32'h1);
      en = 1'b0; tick();
      check("en0_hold_q", 32'(q), 32'h92);
      sin_r = 1'b0;

      // Burst rotate right by 3 from 81.
      load(8'h81);
      mode = 3'b101; start = 1'b1; count = 4'd3; tick();
      check("b3_e0_q",    32'(q),    32'h81);
      check("b3_e0_busy", 32'(busy), 32'h1);
      check("b3_e0_done", 32'(done), 32'h0);
      // The live mode is left-type, but sout must follow the captured ror mode.
      start = 1'b0; mode = 3'b010; tick();
      check("b3_e1_q",    32'(q),    32'hC0);
      check("b3_e1_busy", 32'(busy), 32'h1);
      check("b3_e1_sout", 32'(sout), 32'h0);
      tick();
      check("b3_e2_q",    32'(q),    32'h60);
      check("b3_e2_busy", 32'(busy), 32'h1);
      tick();
      check("b3_e3_q",    32'(q),    32'h30);
      check("b3_e3_busy", 32'(busy), 32'h0);
      check("b3_e3_done", 32'(done), 32'h1);
      tick();
      check("b3_e4_done", 32'(done), 32'h0);
      check("b3_e4_q",    32'(q),    32'h30);

      // Burst shift left by 5 with sin_l=1. A disruptive request mid-burst is ignored.
      load(8'h01);
      mode = 3'b010; sin_l = 1'b1; start = 1'b1; count = 4'd5; tick();
      check("b5_e0_busy", 32'(busy), 32'h1);
      start = 1'b0; tick();
      check("b5_e1_q", 32'(q), 32'h03);
      mode = 3'b000; en = 1'b1; start = 1'b1; count = 4'd1; tick();
      check("b5_e2_q",    32'(q),    32'h07);
      check("b5_e2_done", 32'(done), 32'h0);
      start = 1'b0; en = 1'b0; tick();
      check("b5_e3_q", 32'(q), 32'h0F);
      tick();
      check("b5_e4_q",    32'(q),    32'h1F);
      check("b5_e4_done", 32'(done), 32'h0);
      tick();
      check("b5_e5_q",    32'(q),    32'h3F);
      check("b5_e5_busy", 32'(busy), 32'h0);
      check("b5_e5_done", 32'(done), 32'h1);
      tick();
      check("b5_e6_done", 32'(done), 32'h0);
      sin_l = 1'b0;

      // count=0 and non-shift modes complete at once, with no busy cycle.
      mode = 3'b010; start = 1'b1; count = 4'd0; tick();
      check("c0_done", 32'(done), 32'h1);
      check("c0_busy", 32'(busy), 32'h0);
      check("c0_q",    32'(q),    32'h3F);
      start = 1'b0; tick();
      check("c0_done_clr", 32'(done), 32'h0);
      mode = 3'b001; d = 8'h00; en = 1'b1; start = 1'b1; count = 4'd4; tick();
      check("ld_start_done", 32'(done), 32'h1);
      check("ld_start_busy", 32'(busy), 32'h0);
      check("ld_start_q",    32'(q),    32'h3F);

      // A new start in the cycle where done=1 is accepted.
      en = 1'b0; mode = 3'b100; count = 4'd2; tick();
      check("rs_e0_busy", 32'(busy), 32'h1);
      check("rs_e0_done", 32'(done), 32'h0);
      check("rs_e0_q",    32'(q),    32'h3F);
      start = 1'b0; tick();
      check("rs_e1_q", 32'(q), 32'h7E);
      tick();
      check("rs_e2_q",    32'(q),    32'hFC);
      check("rs_e2_done", 32'(done), 32'h1);

      // Preset aborts a burst with no done pulse.
      load(8'h0F);
      mode = 3'b011; sin_r = 1'b0; start = 1'b1; count = 4'd6; tick();
      start = 1'b0; tick();
      check("pa_e1_q", 32'(q), 32'h07);
      pre = 1'b1; tick();
      check("pa_q",    32'(q),    32'hFF);
      check("pa_busy", 32'(busy), 32'h0);
      check("pa_done", 32'(done), 32'h0);
      pre = 1'b0; tick();
      check("pa_next_done", 32'(done), 32'h0);
      check("pa_next_q",    32'(q),    32'hFF);

      // Reset aborts a burst with no done pulse.
      load(8'h0F);
      mode = 3'b011; start = 1'b1; count = 4'd6; tick();
      start = 1'b0; tick();
      check("ra_e1_q", 32'(q), 32'h07);
      res = 1'b1; tick();
      check("ra_q",    32'(q),    32'h00);
      check("ra_busy", 32'(busy), 32'h0);
      check("ra_done", 32'(done), 32'h0);
      res = 1'b0; tick();
      check("ra_next_done", 32'(done), 32'h0);
      check("ra_next_busy", 32'(busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width in bits (>=2).
REQ-002 SHALL have parameter CNT_W, default 4: width of burst shift count.
REQ-003 SHALL have parameter PRE_VAL, default all-ones of WIDTH: value loaded by preset.
REQ-004 SHALL have port clk  input  1  rising-edge clock; all state changes on posedge clk only.
REQ-005 SHALL have port res  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port pre  input  1  synchronous active-high preset.
REQ-007 SHALL have port en  input  1  single-step operation enable.
REQ-008 SHALL have port mode  input  3  operation select (see REQ-013).
REQ-009 SHALL have port d  input  WIDTH  parallel load data.
REQ-010 SHALL have ports sin_l / sin_r  input  1 each  serial in for left shift (enters bit 0) and right shift (enters bit WIDTH-1).
REQ-011 SHALL have ports start  input  1 and count  input  CNT_W  burst request and shift count.
REQ-012 SHALL have outputs q  WIDTH  register value; sout  1  serial out; busy  1  burst active; done  1  burst-complete pulse.

Function
REQ-013 mode SHALL decode: 000 hold, 001 load d, 010 shift left (sin_l in), 011 shift right (sin_r in), 100 rotate left, 101 rotate right, 110 arithmetic shift right (MSB replicated), 111 hold.
REQ-014 Per-edge priority SHALL be: res > pre > burst in progress > start > en single-step > hold.
REQ-015 pre=1 (res=0) SHALL set q=PRE_VAL, abort any burst (busy=0), done=0.
REQ-016 In IDLE with start=0, en=1: q SHALL update by one mode operation at the edge; en=0: q holds.
REQ-017 FSM SHALL have two states IDLE and RUN; busy=1 exactly in RUN.
REQ-018 start sampled high in IDLE with shift/rotate mode (010-110) and count=N>0: SHALL latch mode and N, enter RUN at that edge (edge 0); q unchanged at edge 0.
REQ-019 In RUN SHALL perform one latched-mode operation per edge, edges 1..N; mode, en, d, start ignored.
REQ-020 At edge N SHALL return to IDLE (busy=0) and set done=1; done SHALL clear at next edge unless re-set.
REQ-021 start with count=0, or with mode 000/001/111: SHALL set done=1 at edge 0, stay IDLE, q unchanged.
REQ-022 start while busy SHALL be ignored (no queueing); start in the cycle done=1 SHALL be accepted.
REQ-023 sin_l/sin_r SHALL be sampled live on every shifting edge, including during RUN.
REQ-024 sout SHALL be combinational: q[WIDTH-1] when effective mode is left-type (010,100), else q[0]; effective mode = latched mode when busy, else mode input.
REQ-025 Burst count SHALL be unsigned; max N = 2^CNT_W-1; rotate counts >= WIDTH wrap naturally.

Reset
REQ-026 res=1 at an edge SHALL set q=0, busy=0, done=0, FSM=IDLE, internal count=0, regardless of pre, start, en, or state.
REQ-027 Reset mid-burst SHALL abort it with no done pulse.
REQ-028 Release of res SHALL need no extra cycles; first edge with res=0 processes inputs normally.

Verification (WIDTH=8, CNT_W=4, PRE_VAL=FF)
REQ-029 res=1, pre=1, start=1 one edge -> q=00, busy=0, done=0; next edge res=0, pre=1 -> q=FF.
REQ-030 q=00, mode=001, d=A5, en=1 -> q=A5; mode=100 en=1 -> q=4B; mode=110 -> q=25; mode=011 sin_r=1 -> q=92.
REQ-031 q=81, mode=101, start=1, count=3 -> busy 1 for edges 0..2, q=C0,60,30 at edges 1..3, busy=0 and done=1 after edge 3, done=0 after edge 4.
REQ-032 q=01, mode=010, sin_l=1, count=5 burst; at edge 2 drive mode=000, en=1, start=1 -> ignored; final q=3F, single done pulse.
REQ-033 count=0 start -> done=1 one cycle, busy never 1, q unchanged; mode=001 start count=4 -> same, q unchanged.
REQ-034 burst count=6 from q=0F; pre=1 at edge 2 -> q=FF, busy=0, no done; repeat with res=1 -> q=00, no done.
